uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 20 ++
 rtl/uart_tx_baud_gen.sv | 32 +++
 rtl/uart_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared PicoIO helpers (counter width function)
package uart_tx_pkg;

    // Number of bits needed to hold values 0..value-1 (ceil(log2(value)), minimum 1).
    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        if (width == 0) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// rtl/uart_tx_baud_gen.sv - bit period timer, one-cycle tick per CLKS_PER_BIT clocks
module baud_gen
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Tick marks the last clock of the current bit period.
    assign tick = (cnt == CNT_LAST);

    // Baud counter: held at zero by clear, wraps to zero on each bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter popping words directly from an upstream FIFO
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dataPresent,
    input  logic [DATA_BITS-1:0] dataIn,
    output logic                 read,
    output logic                 serialOut,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int BIT_W = clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    state_t               state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [BIT_W-1:0]     bitcnt, bitcnt_n;
    logic                 serial_n;
    logic                 clear;
    logic                 tick;

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    // State, shift register, bit counter and the registered line output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            serialOut <= 1'b1;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bitcnt    <= bitcnt_n;
            serialOut <= serial_n;
        end
    end

    // Next-state logic; serial_n is the line level for the cycle after the edge,
    // so the start bit appears the cycle after the read pulse.
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bitcnt_n = bitcnt;
        serial_n = serialOut;
        read     = 1'b0;
        busy     = 1'b1;
        clear    = 1'b0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                clear    = 1'b1;
                serial_n = 1'b1;
                if (dataPresent) begin
                    read     = 1'b1;
                    shreg_n  = dataIn;
                    bitcnt_n = '0;
                    serial_n = 1'b0;
                    state_n  = START;
                end
            end
            START: begin
                if (tick) begin
                    serial_n = shreg[0];
                    bitcnt_n = '0;
                    state_n  = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_n = shreg >> 1;
                    if (bitcnt == LAST_DATA) begin
                        serial_n = 1'b1;
                        bitcnt_n = '0;
                        state_n  = STOP;
                    end else begin
                        serial_n = shreg[1];
                        bitcnt_n = bitcnt + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                serial_n = 1'b1;
                if (tick) begin
                    if (bitcnt == LAST_STOP) begin
                        bitcnt_n = '0;
                        state_n  = IDLE;
                    end else begin
                        bitcnt_n = bitcnt + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // The FIFO must never see a pop while the block is held in reset.
        if (rst) begin
            read = 1'b0;
        end
    end

endmodule
